// File: rtl/jtframe_dwnld_pkg.sv
// jtframe_dwnld_pkg: shared types and defaults for the ioctl-to-SDRAM
// download buffer.
//   dwnld_entry_t : one queued SDRAM byte write {bank, waddr, mask, data}
//   dwnld_state_t : request FSM states (IDLE / WAIT)
//   map_byte()    : maps a 25-bit download byte address to bank/word/mask
package jtframe_dwnld_pkg;

  localparam logic [24:0] BA1_START_DEF  = 25'h080000;
  localparam logic [24:0] BA2_START_DEF  = 25'h100000;
  localparam logic [24:0] BA3_START_DEF  = 25'h180000;
  localparam logic [24:0] PROM_START_DEF = 25'h1F0000;

  typedef struct packed {
    logic [1:0]  bank;
    logic [21:0] waddr;
    logic [1:0]  mask;   // active-low byte lane enable
    logic [7:0]  data;
  } dwnld_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dwnld_state_t;

  // Offsets are taken at 25 bits and the word address keeps only bits 22:1,
  // so each bank wraps every 8 MB.
  function automatic dwnld_entry_t map_byte(
    input logic [24:0] addr,
    input logic [7:0]  data,
    input logic [24:0] ba1,
    input logic [24:0] ba2,
    input logic [24:0] ba3
  );
    dwnld_entry_t e;
    logic [24:0]  start;
    logic [24:0]  off;
    if (addr >= ba3) begin
      e.bank = 2'd3;
      start  = ba3;
    end else if (addr >= ba2) begin
      e.bank = 2'd2;
      start  = ba2;
    end else if (addr >= ba1) begin
      e.bank = 2'd1;
      start  = ba1;
    end else begin
      e.bank = 2'd0;
      start  = '0;
    end
    off     = addr - start;
    e.waddr = 22'(off >> 1);
    e.mask  = off[0] ? 2'b01 : 2'b10;
    e.data  = data;
    return e;
  endfunction

endpackage

// File: rtl/jtframe_dwnld_buf_if.sv
// jtframe_dwnld_buf_if: SDRAM programming port.
//   prog_addr/prog_data/prog_mask/prog_bank/prog_we : write request
//   prog_rd                                          : one-cycle acknowledge
//   master : request side (download buffer); slave : SDRAM controller side
interface jtframe_dwnld_buf_if;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_bank;
  logic        prog_we;
  logic        prog_rd;

  modport master (
    output prog_addr, prog_data, prog_mask, prog_bank, prog_we,
    input  prog_rd
  );

  modport slave (
    input  prog_addr, prog_data, prog_mask, prog_bank, prog_we,
    output prog_rd
  );
endinterface

// File: rtl/jtframe_dwnld_fifo.sv
// jtframe_dwnld_fifo: DEPTH-entry FIFO of dwnld_entry_t.
//   clk_i, rst_i (async, active-high)
//   push_i/din_i : write; ignored when full unless popping in the same cycle
//   pop_i/dout_o : read; dout_o shows the head entry combinationally
//   full_o, empty_o : occupancy flags
module jtframe_dwnld_fifo
  import jtframe_dwnld_pkg::*;
#(
  parameter int unsigned DEPTH = 4
)(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  dwnld_entry_t din_i,
  output dwnld_entry_t dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  dwnld_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          wr_en, rd_en;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/jtframe_dwnld_buf.sv
// jtframe_dwnld_buf: buffers MiSTer ioctl download bytes and issues them one
// at a time as SDRAM prog_we requests, holding each until prog_rd.
//   clk_sys, RESET (async, active-high)
//   downloading, ioctl_wr, ioctl_addr, ioctl_data : HPS download port
//   prog (jtframe_dwnld_buf_if.master)             : SDRAM programming port
//   dwnld_busy : download or flush in progress (registered)
//   overflow   : sticky dropped-byte flag, cleared on downloading rise
// Optional macro JTFRAME_DWNLD_PROM_EN adds prom_we/prom_addr/prom_data; bytes
// at or above PROM_START then go to that port instead of the SDRAM queue.
module jtframe_dwnld_buf
  import jtframe_dwnld_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter logic [24:0] BA1_START  = BA1_START_DEF,
  parameter logic [24:0] BA2_START  = BA2_START_DEF,
  parameter logic [24:0] BA3_START  = BA3_START_DEF
`ifdef JTFRAME_DWNLD_PROM_EN
  , parameter logic [24:0] PROM_START = PROM_START_DEF
`endif
)(
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        downloading,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  jtframe_dwnld_buf_if.master prog,
  output logic        dwnld_busy,
  output logic        overflow
`ifdef JTFRAME_DWNLD_PROM_EN
  , output logic       prom_we,
  output logic [9:0]  prom_addr,
  output logic [7:0]  prom_data
`endif
);
  dwnld_state_t state_q;
  dwnld_entry_t din, head;
  logic         push, pop, full, empty, drop, dl_rise;
  logic [21:0]  prog_addr_q;
  logic [7:0]   prog_data_q;
  logic [1:0]   prog_mask_q, prog_bank_q;
  logic         prog_we_q;
  logic         downloading_q, overflow_q, busy_q, overflow_d;

  assign din = map_byte(ioctl_addr, ioctl_data, BA1_START, BA2_START, BA3_START);

`ifdef JTFRAME_DWNLD_PROM_EN
  assign push = ioctl_wr && (ioctl_addr < PROM_START);
`else
  assign push = ioctl_wr;
`endif

  // Pop is the IDLE-state issue; it frees a slot in the same edge, so a
  // push into a full FIFO is only dropped when no issue happens.
  assign pop     = (state_q == IDLE) && !empty;
  assign drop    = push && full && !pop;
  assign dl_rise = downloading && !downloading_q;

  jtframe_dwnld_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_sys),
    .rst_i   (RESET),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      prog_we_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mask_q <= '1;
      prog_bank_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (!empty) begin
          prog_addr_q <= head.waddr;
          prog_data_q <= head.data;
          prog_mask_q <= head.mask;
          prog_bank_q <= head.bank;
          prog_we_q   <= 1'b1;
          state_q     <= WAIT;
        end
        WAIT: if (prog.prog_rd) begin
          prog_we_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A drop in the same cycle as a downloading rise still leaves the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (dl_rise) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      downloading_q <= 1'b0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      downloading_q <= downloading;
      overflow_q    <= overflow_d;
      busy_q        <= downloading || !empty || prog_we_q;
    end
  end

`ifdef JTFRAME_DWNLD_PROM_EN
  logic       prom_we_q;
  logic [9:0] prom_addr_q;
  logic [7:0] prom_data_q;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      prom_we_q   <= 1'b0;
      prom_addr_q <= '0;
      prom_data_q <= '0;
    end else begin
      prom_we_q <= ioctl_wr && (ioctl_addr >= PROM_START);
      if (ioctl_wr && (ioctl_addr >= PROM_START)) begin
        prom_addr_q <= 10'(ioctl_addr - PROM_START);
        prom_data_q <= ioctl_data;
      end
    end
  end

  assign prom_we   = prom_we_q;
  assign prom_addr = prom_addr_q;
  assign prom_data = prom_data_q;
`endif

  assign prog.prog_addr = prog_addr_q;
  assign prog.prog_data = prog_data_q;
  assign prog.prog_mask = prog_mask_q;
  assign prog.prog_bank = prog_bank_q;
  assign prog.prog_we   = prog_we_q;
  assign dwnld_busy     = busy_q;
  assign overflow       = overflow_q;
endmodule

// File: tb/tb_jtframe_dwnld_buf.sv
// tb_jtframe_dwnld_buf: directed bench for jtframe_dwnld_buf (DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_jtframe_dwnld_buf;
  logic        clk_sys     = 1'b0;
  logic        RESET       = 1'b1;
  logic        downloading = 1'b0;
  logic        ioctl_wr    = 1'b0;
  logic [24:0] ioctl_addr  = '0;
  logic [7:0]  ioctl_data  = '0;
  logic        dwnld_busy, overflow;
`ifdef JTFRAME_DWNLD_PROM_EN
  logic        prom_we;
  logic [9:0]  prom_addr;
  logic [7:0]  prom_data;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  jtframe_dwnld_buf_if prog_if ();

  jtframe_dwnld_buf #(.DEPTH(4)) dut (
    .clk_sys     (clk_sys),
    .RESET       (RESET),
    .downloading (downloading),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .prog        (prog_if),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow)
`ifdef JTFRAME_DWNLD_PROM_EN
    , .prom_we   (prom_we),
    .prom_addr   (prom_addr),
    .prom_data   (prom_data)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_data = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic ack();
    prog_if.prog_rd = 1'b1;
    tick();
    prog_if.prog_rd = 1'b0;
  endtask

  task automatic wait_we(input int unsigned budget);
    int unsigned n = 0;
    while (prog_if.prog_we !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("we_timeout", prog_if.prog_we, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},   prog_if.prog_we,   0);
    chk({tag, "_addr"}, prog_if.prog_addr, 0);
    chk({tag, "_data"}, prog_if.prog_data, 0);
    chk({tag, "_mask"}, prog_if.prog_mask, 2'b11);
    chk({tag, "_bank"}, prog_if.prog_bank, 0);
    chk({tag, "_busy"}, dwnld_busy,        0);
    chk({tag, "_ovf"},  overflow,          0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    prog_if.prog_rd = 1'b0;
    tick();
    tick();
    chk_reset_vals("rst");
    RESET = 1'b0;
    tick();

    // Single byte: odd address 3 -> word 1, high lane
    strobe(25'h000003, 8'hA5);
    chk("single_we_early", prog_if.prog_we, 0);
    tick();
    chk("single_we",   prog_if.prog_we,   1);
    chk("single_addr", prog_if.prog_addr, 1);
    chk("single_mask", prog_if.prog_mask, 2'b01);
    chk("single_bank", prog_if.prog_bank, 0);
    chk("single_data", prog_if.prog_data, 8'hA5);
    repeat (4) tick();
    chk("single_hold_we",   prog_if.prog_we,   1);
    chk("single_hold_data", prog_if.prog_data, 8'hA5);
    ack();
    chk("single_we_drop", prog_if.prog_we, 0);
    ack();                       // acknowledge in IDLE is ignored
    tick();
    chk("idle_rd_ignored", prog_if.prog_we, 0);

    // Bank boundary
    strobe(25'h07FFFF, 8'h11);
    strobe(25'h080000, 8'h22);
    chk("b0_bank", prog_if.prog_bank, 0);
    chk("b0_addr", prog_if.prog_addr, 22'h3FFFF);
    chk("b0_mask", prog_if.prog_mask, 2'b01);
    ack();
    tick();
    chk("b1_we",   prog_if.prog_we,   1);
    chk("b1_bank", prog_if.prog_bank, 1);
    chk("b1_addr", prog_if.prog_addr, 0);
    chk("b1_mask", prog_if.prog_mask, 2'b10);
    chk("b1_data", prog_if.prog_data, 8'h22);
    ack();
    tick();

    // Overflow: one in flight + 4 queued, sixth byte dropped
    downloading = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) strobe(25'h10 + 25'(i), 8'h10 + 8'(i));
    chk("ovf_before", overflow, 0);
    strobe(25'h15, 8'h15);
    chk("ovf_set",    overflow, 1);
    chk("ovf_head",   prog_if.prog_data, 8'h10);
    for (int k = 1; k < 5; k++) begin
      ack();
      tick();
      chk("ovf_order", prog_if.prog_data, 8'h10 + 8'(k));
    end
    ack();
    tick();
    chk("ovf_dropped", prog_if.prog_we, 0);
    chk("ovf_sticky",  overflow, 1);
    downloading = 1'b0;
    tick();
    downloading = 1'b1;
    tick();
    chk("ovf_clear", overflow, 0);

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < 5; i++) strobe(25'h40 + 25'(i), 8'h40 + 8'(i));
    chk("pp_head", prog_if.prog_data, 8'h40);
    ack();
    strobe(25'h45, 8'h45);
    chk("pp_no_ovf", overflow, 0);
    chk("pp_issue",  prog_if.prog_data, 8'h41);
    for (int k = 2; k < 6; k++) begin
      ack();
      tick();
      chk("pp_order", prog_if.prog_data, 8'h40 + 8'(k));
    end
    ack();
    tick();
    chk("pp_empty",   prog_if.prog_we, 0);
    chk("pp_no_ovf2", overflow, 0);

    // Flush after downloading falls with 3 queued
    for (int i = 0; i < 4; i++) strobe(25'h200 + 25'(i), 8'h30 + 8'(i));
    downloading = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_we(10);
      chk("flush_data", prog_if.prog_data, 8'h30 + 8'(k));
      repeat (3) tick();
      chk("flush_busy", dwnld_busy, 1);
      ack();
      chk("flush_we_drop", prog_if.prog_we, 0);
      chk("flush_busy_ack", dwnld_busy, 1);
    end
    tick();
    chk("flush_busy_done", dwnld_busy, 0);

    // Asynchronous reset while a request is pending
    downloading = 1'b1;
    strobe(25'h300, 8'h5A);
    strobe(25'h301, 8'h5B);
    strobe(25'h302, 8'h5C);
    chk("rw_we_pre", prog_if.prog_we, 1);
    #3;
    RESET       = 1'b1;
    downloading = 1'b0;
    #1;
    chk_reset_vals("rw");
    tick();
    RESET = 1'b0;
    tick();
    tick();
    chk("rw_fifo_empty", prog_if.prog_we, 0);
    chk("rw_busy",       dwnld_busy, 0);

`ifdef JTFRAME_DWNLD_PROM_EN
    chk("prom_rst", prom_we, 0);
    strobe(25'h1F0005, 8'h77);
    chk("prom_we",     prom_we,   1);
    chk("prom_addr",   prom_addr, 10'd5);
    chk("prom_data",   prom_data, 8'h77);
    chk("prom_no_sdr", prog_if.prog_we, 0);
    tick();
    chk("prom_pulse",   prom_we, 0);
    chk("prom_no_sdr2", prog_if.prog_we, 0);
    chk("prom_no_ovf",  overflow, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/jtframe_dwnld_buf.md
Name: jtframe_dwnld_buf

Overview:
- Sits between the MiSTer ioctl download port and the SDRAM programming port of the frame.
- Accepts ROM bytes streamed from the HPS on ioctl_wr strobes and buffers them in a small FIFO.
- Maps each byte's address into an SDRAM bank, word address and byte mask.
- Issues each byte as a prog_we request that is held until the SDRAM controller acknowledges it.
- Drives dwnld_busy, which keeps the game held in reset until every byte is committed.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- BA1_START, 25'h080000: first byte address mapped to bank 1.
- BA2_START, 25'h100000: first byte address mapped to bank 2.
- BA3_START, 25'h180000: first byte address mapped to bank 3; all bank starts are strictly increasing.
- PROM_START, 25'h1F0000: first byte address of the PROM region; used only with the optional feature.

Ports:
- clk_sys  in  1  system clock (48 or 96 MHz).
- RESET  in  1  asynchronous, active-high reset.
- downloading  in  1  HPS download window active.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_data  in  8  byte value.
- prog_addr  out  22  SDRAM word address within the bank.
- prog_data  out  8  byte to write.
- prog_mask  out  2  active-low byte enable.
- prog_bank  out  2  SDRAM bank.
- prog_we  out  1  write request; held high until acknowledged.
- prog_rd  in  1  one-cycle acknowledge from the SDRAM controller.
- dwnld_busy  out  1  download or flush still in progress.
- overflow  out  1  sticky flag: a byte was dropped.

Behaviour:
- Reset values: prog_we=0, prog_addr=0, prog_data=0, prog_mask=2'b11, prog_bank=0, dwnld_busy=0, overflow=0. FIFO is emptied. Reset asserted mid-transfer abandons the pending request immediately.
- Bank mapping is combinational at push time:
  - bank = 3 if addr>=BA3_START; else 2 if addr>=BA2_START; else 1 if addr>=BA1_START; else 0.
  - off = addr - start of that bank, computed at 25 bits.
  - prog_addr = off[22:1]; higher bits are discarded, so addresses wrap modulo 8 MB per bank.
  - prog_mask = off[0] ? 2'b01 : 2'b10. Even byte goes to the low lane, odd byte to the high lane.
- FIFO entry holds {bank, word address, mask, data}.
- Push happens on any clk edge where ioctl_wr=1. It does not depend on the downloading level.
- State machine:
  - IDLE: if the FIFO is not empty, load the head entry into the prog_* registers, pop it, set prog_we=1, and go to WAIT. First prog_we is therefore 2 cycles after the ioctl_wr strobe.
  - WAIT: hold prog_we and all prog_* outputs stable. On prog_rd=1, clear prog_we and go to IDLE. Earliest next request is 2 cycles after the acknowledge; no back-to-back requests.
  - prog_rd seen in IDLE is ignored.
- Full FIFO:
  - Push with full=1 and no pop in the same cycle drops the byte and sets overflow.
  - Push and pop in the same cycle while full is legal; nothing is dropped.
  - Empty FIFO with a simultaneous push and IDLE: the entry is pushed this cycle and issued the next cycle. No bypass path.
- overflow clears on a rising edge of downloading (edge detect on a registered copy).
- dwnld_busy = downloading | FIFO not empty | prog_we, registered (1-cycle delay). After downloading falls, busy stays high until the final prog_rd has been processed.

Optional Feature:
- Macro: JTFRAME_DWNLD_PROM_EN.
- When defined:
  - Adds outputs prom_we (1 bit), prom_addr (10 bits) and prom_data (8 bits).
  - Bytes with addr>=PROM_START bypass the FIFO and are never sent to SDRAM.
  - Registered outputs, 1-cycle latency: prom_we pulses one cycle, prom_addr = (addr-PROM_START)[9:0], prom_data = the byte.
  - These bytes never set overflow.
  - Reset values: prom_we=0, prom_addr=0, prom_data=0.
- When undefined: the ports are absent and PROM_START is ignored; every byte follows the SDRAM path.

Decomposition:
- Package jtframe_dwnld_pkg:
  - typedef dwnld_entry_t {bank, waddr, mask, data}.
  - Enum IDLE/WAIT.
  - Constants for the default bank starts.
- One sub-module, jtframe_dwnld_fifo: parameterised DEPTH, push/pop/full/empty, holds dwnld_entry_t.
- Bank mapping and the FSM stay in the top module.

Test Plan:
- Single byte: ioctl_wr with addr 25'h000003, data 8'hA5.
  - prog_we rises 2 cycles later with prog_addr=1, mask=2'b01, bank=0, data=8'hA5.
  - With prog_rd 5 cycles later, prog_we drops the following cycle.
- Bank boundary: addrs 25'h07FFFF then 25'h080000.
  - First: bank 0, prog_addr=22'h3FFFF, mask=2'b01.
  - Second: bank 1, prog_addr=0, mask=2'b10.
- Overflow: DEPTH=4, prog_rd held low, 6 strobes.
  - The request in flight plus 4 FIFO entries are held; the 6th byte is dropped and overflow=1.
  - Next downloading rise clears overflow.
- Flush: downloading falls with 3 entries queued and prog_rd acking 4 cycles after each request.
  - dwnld_busy stays 1 and falls 1 cycle after the last acknowledge is processed.
- Full push/pop: FIFO full, strobe on the same edge as a pop (IDLE issue after an ack).
  - No drop; overflow stays 0; all bytes come out in order.
- Reset mid-WAIT: RESET pulsed while prog_we=1.
  - All outputs return to reset values asynchronously.
  - With JTFRAME_DWNLD_PROM_EN: addr PROM_START+5 gives prom_we pulse and prom_addr=5, with no prog_we.
